// File: rtl/iiitb_sd_sched.sv
// Round-robin scheduler that time-shares one Moore sequence detector among N_REQ requesters.
// Each granted word is shifted MSB-first into the detector and its output pulses are counted.
module iiitb_sd_sched #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    busy,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [CNT_W-1:0]        match_cnt,
    output logic                    sd_seq_out,
    output logic                    sd_rst,
    input  logic                    sd_det_in
);

    localparam int unsigned BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shreg;
    logic [BC_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
    logic [ID_W-1:0]     id, last;
    logic [ID_W-1:0]     win, cand;
    logic                found, arb;
    logic [DATA_W-1:0]   word;
    logic [N_REQ-1:0]    gnt_nxt;
    logic                busy_nxt, done_nxt, sd_seq_nxt, sd_rst_nxt;

    // Round-robin search starting just after the last winner.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = last + ID_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) word = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        arb        = 1'b0;
        gnt_nxt    = '0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        sd_seq_nxt = 1'b0;
        sd_rst_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (gnt != '0) state_nxt = CLR;
                else           arb       = 1'b1;
            end
            CLR:   state_nxt = SHIFT;
            SHIFT: begin
                if ((bit_cnt != '0) && sd_det_in) cnt_nxt = cnt_inc;
                if (bit_cnt == LAST_BIT) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (sd_det_in) cnt_nxt = cnt_inc;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                arb       = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (arb && found) begin
            gnt_nxt = N_REQ'(1) << win;
            cnt_nxt = '0;
        end
        busy_nxt   = (state_nxt != IDLE);
        sd_rst_nxt = (state_nxt == CLR);
        done_nxt   = (state_nxt == DONE);
        if (state_nxt == SHIFT) sd_seq_nxt = shreg[DATA_W-1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            cnt        <= '0;
            id         <= '0;
            last       <= ID_W'(N_REQ - 1);
            gnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= '0;
            match_cnt  <= '0;
            sd_seq_out <= 1'b0;
            sd_rst     <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            gnt        <= gnt_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            sd_seq_out <= sd_seq_nxt;
            sd_rst     <= sd_rst_nxt;
            if (arb && found) begin
                shreg <= word;
                id    <= win;
                last  <= win;
            end else if (state_nxt == SHIFT) begin
                shreg <= shreg << 1;
            end
            if (state == CLR)        bit_cnt <= '0;
            else if (state == SHIFT) bit_cnt <= bit_cnt + BC_W'(1);
            if (state_nxt == DONE) begin
                done_id   <= id;
                match_cnt <= cnt_nxt;
            end
        end
    end

endmodule
